spi_frame_tx: RTL and testbench

- Serial frame transmitter that drives the `spi_fs` / `spi_data` pair the chip's pad ring receives.
- Used as the host-side driver in chip-level testbenches, and as the on-board controller model on the FPGA bring-up board.
- Takes parallel words over a valid/ready handshake.
- Emits each word as a frame-sync bit, then the data bits MSB first, then an idle gap. All timing is derived from a single clock via a bit-period divider.

---
 rtl/spi_frame_pkg.sv | 28 ++
 rtl/spi_frame_tx_bit_tick.sv | 32 +++
 rtl/spi_frame_tx.sv | 162 ++++++++++++++++
 tb/tb_spi_frame_tx.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg: shared types and constants for the spi_frame_tx serial frame transmitter.
//   state_e      - transmitter FSM states
//   *_DEF        - default parameter values
//   frame_cycles - clk cycles from one accept edge to the next possible accept edge
package spi_frame_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StShift,
    StParity,
    StGap
  } state_e;

  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned CLK_DIV_DEF  = 4;
  localparam int unsigned GAP_BITS_DEF = 1;

  // Sync + data + optional parity + gap bit periods, plus the single IDLE cycle in which
  // tx_ready is seen high again. This is also the back-to-back frame period.
  function automatic int unsigned frame_cycles(input int unsigned data_w,
                                               input int unsigned clk_div,
                                               input int unsigned gap,
                                               input int unsigned parity);
    return (1 + data_w + parity + gap) * clk_div + 1;
  endfunction

endpackage

// File: rtl/spi_frame_tx_bit_tick.sv
// spi_bit_tick: bit-period divider for spi_frame_tx.
//   clk   - system clock
//   reset - synchronous active-high reset
//   clr   - synchronous clear; the next cycle is the first of a new bit period
//   tick  - high on the last clk cycle of each CLK_DIV-cycle bit period
module spi_bit_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned    CntW   = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = (cnt_q == CntMax);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/spi_frame_tx.sv
// spi_frame_tx: serial frame transmitter. Each accepted word is sent as one frame-sync bit
// period, DATA_W data bits MSB first, then GAP_BITS idle bit periods.
// Optional build macro SPI_FRAME_TX_PARITY_EN adds one even-parity bit after the LSB.
//   clk      - system clock, rising edge
//   reset    - synchronous active-high reset
//   tx_data  - word to send, sampled on the accept edge only
//   tx_valid - word available
//   tx_ready - block can accept a word (IDLE only)
//   spi_fs   - frame sync, high for one bit period before the MSB
//   spi_data - serial data, MSB first
//   busy     - high from the accept edge through the last gap bit
module spi_frame_tx
  import spi_frame_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
  parameter int unsigned GAP_BITS = GAP_BITS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              spi_fs,
  output logic              spi_data,
  output logic              busy
);

  localparam int unsigned       BitCntW = $clog2(DATA_W + 1);
  localparam int unsigned       GapCntW = $clog2(GAP_BITS + 1);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_W - 1);
  localparam logic [GapCntW-1:0] LastGap = GapCntW'(GAP_BITS - 1);
`ifdef SPI_FRAME_TX_PARITY_EN
  localparam int unsigned ParityBits = 1;
`else
  localparam int unsigned ParityBits = 0;
`endif

  state_e             state_q;
  logic [DATA_W-1:0]  shift_q;
  logic [BitCntW-1:0] bit_cnt_q;
  logic [GapCntW-1:0] gap_cnt_q;
`ifdef SPI_FRAME_TX_PARITY_EN
  logic               parity_q;
`endif
  logic               accept;
  logic               bit_end;

  // tx_ready is only ever high in IDLE, so this cannot fire mid-frame.
  assign accept = tx_valid && tx_ready;

  spi_bit_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .tick  (bit_end)
  );

  // Outputs are loaded with the value for the state being entered, so they change on the
  // same edge as the state and stay aligned with the divider phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
`ifdef SPI_FRAME_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
      tx_ready  <= 1'b0;
      busy      <= 1'b0;
      spi_fs    <= 1'b0;
      spi_data  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          spi_fs   <= 1'b0;
          spi_data <= 1'b0;
          if (accept) begin
            shift_q   <= tx_data;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
`ifdef SPI_FRAME_TX_PARITY_EN
            parity_q  <= ^tx_data;
`endif
            tx_ready  <= 1'b0;
            busy      <= 1'b1;
            spi_fs    <= 1'b1;
            state_q   <= StSync;
          end else begin
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        StSync: begin
          if (bit_end) begin
            spi_fs   <= 1'b0;
            spi_data <= shift_q[DATA_W-1];
            state_q  <= StShift;
          end
        end
        StShift: begin
          if (bit_end) begin
            if (bit_cnt_q == LastBit) begin
`ifdef SPI_FRAME_TX_PARITY_EN
              spi_data <= parity_q;
              state_q  <= StParity;
`else
              spi_data <= 1'b0;
              state_q  <= StGap;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + BitCntW'(1);
              shift_q   <= {shift_q[DATA_W-2:0], 1'b0};
              spi_data  <= shift_q[DATA_W-2];
            end
          end
        end
        StParity: begin
          if (bit_end) begin
            spi_data <= 1'b0;
            state_q  <= StGap;
          end
        end
        StGap: begin
          if (bit_end) begin
            if (gap_cnt_q == LastGap) begin
              tx_ready <= 1'b1;
              busy     <= 1'b0;
              state_q  <= StIdle;
            end else begin
              gap_cnt_q <= gap_cnt_q + GapCntW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifndef SYNTHESIS
  localparam int unsigned FrameCycles = frame_cycles(DATA_W, CLK_DIV, GAP_BITS, ParityBits);

  // Cycles since the accept edge; a frame must never outlast its nominal length.
  int unsigned age_q;

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      age_q <= 0;
    end else if (busy) begin
      age_q <= age_q + 1;
    end
    if (!reset && busy) begin
      assert (age_q + 32'd2 <= FrameCycles);
      assert (!tx_ready);
    end
  end
`endif

endmodule

// File: tb/tb_spi_frame_tx.sv
// Self-checking bench for spi_frame_tx: a default-parameter instance plus a
// DATA_W=8 / CLK_DIV=2 / GAP_BITS=3 instance. Cycle k is the value seen between
// clock edge k-1 and edge k, with the accept edge numbered 0.
module tb_spi_frame_tx;
  import spi_frame_pkg::*;

`ifdef SPI_FRAME_TX_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam int unsigned W  = 16;
  localparam int unsigned D  = 4;
  localparam int unsigned G  = 1;
  localparam int unsigned SW = 8;
  localparam int unsigned SD = 2;
  localparam int unsigned SG = 3;
  // 73 cycles for the defaults, 77 with the parity bit.
  localparam int unsigned FRAME  = frame_cycles(W, D, G, PAR);
  localparam int unsigned SFRAME = frame_cycles(SW, SD, SG, PAR);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, spi_fs, spi_data, busy;
  logic [7:0]  s_tx_data = '0;
  logic        s_tx_valid = 1'b0;
  logic        s_tx_ready, s_spi_fs, s_spi_data, s_busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  spi_frame_tx dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .spi_fs   (spi_fs),
    .spi_data (spi_data),
    .busy     (busy)
  );

  spi_frame_tx #(
    .DATA_W   (SW),
    .CLK_DIV  (SD),
    .GAP_BITS (SG)
  ) dut_s (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (s_tx_data),
    .tx_valid (s_tx_valid),
    .tx_ready (s_tx_ready),
    .spi_fs   (s_spi_fs),
    .spi_data (s_spi_data),
    .busy     (s_busy)
  );

  // Expected {spi_fs, spi_data, busy, tx_ready} at cycle k (k >= 1) of a frame carrying w.
  function automatic logic [3:0] exp_out(input logic [31:0] w, input int unsigned k,
                                         input int unsigned dw, input int unsigned dv,
                                         input int unsigned gp);
    int unsigned last;
    logic        fs, dat;
    logic [31:0] mask;
    last = (1 + dw + PAR + gp) * dv;
    mask = 32'((64'd1 << dw) - 64'd1);
    fs   = 1'b0;
    dat  = 1'b0;
    if (k >= 1 && k <= dv) fs = 1'b1;
    else if (k > dv && k <= (1 + dw) * dv) dat = w[dw - 1 - (k - dv - 1) / dv];
    else if (PAR == 1 && k > (1 + dw) * dv && k <= (2 + dw) * dv) dat = ^(w & mask);
    return {fs, dat, (k >= 1 && k <= last), (k == last + 1)};
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL wait_ready: tx_ready=%b, want 1 within 300 cycles", tx_ready);
    end
  endtask

  task automatic send(input logic [15:0] w);
    wait_ready();
    tx_data  = w;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({tx_ready, spi_fs, spi_data, busy, s_tx_ready, s_spi_fs, s_spi_data, s_busy} !== 8'h00)
    begin
      bad++;
      $display("FAIL reset_values: got %b want 00000000",
               {tx_ready, spi_fs, spi_data, busy, s_tx_ready, s_spi_fs, s_spi_data, s_busy});
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({tx_ready, busy, s_tx_ready, s_busy} !== 4'b1010) begin
      bad++;
      $display("FAIL ready_after_reset: ready/busy/s_ready/s_busy=%b want 1010",
               {tx_ready, busy, s_tx_ready, s_busy});
    end
  endtask

  task automatic test_single();
    logic [3:0] e;
    send(16'hA5C3);
    for (int k = 1; k <= int'(FRAME); k++) begin
      @(negedge clk);
      e = exp_out(32'hA5C3, k, W, D, G);
      total++;
      if ({spi_fs, spi_data, busy, tx_ready} !== e) begin
        bad++;
        $display("FAIL single_a5c3 cycle %0d: fs/data/busy/ready=%b want %b",
                 k, {spi_fs, spi_data, busy, tx_ready}, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    wait_ready();
    tx_data  = 16'hFFFF;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_data = 16'h0001;
    for (int k = 1; k <= 2 * int'(FRAME); k++) begin
      @(negedge clk);
      if (k <= int'(FRAME)) e = exp_out(32'hFFFF, k, W, D, G);
      else e = exp_out(32'h0001, k - FRAME, W, D, G);
      total++;
      if ({spi_fs, spi_data, busy, tx_ready} !== e) begin
        bad++;
        $display("FAIL back_to_back cycle %0d: fs/data/busy/ready=%b want %b",
                 k, {spi_fs, spi_data, busy, tx_ready}, e);
      end
    end
    tx_valid = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] e;
    send(16'hFFFF);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      e = exp_out(32'hFFFF, k, W, D, G);
      total++;
      if ({spi_fs, spi_data, busy, tx_ready} !== e) begin
        bad++;
        $display("FAIL pre_reset cycle %0d: fs/data/busy/ready=%b want %b",
                 k, {spi_fs, spi_data, busy, tx_ready}, e);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({spi_fs, spi_data, busy, tx_ready} !== 4'b0000) begin
      bad++;
      $display("FAIL mid_reset cycle 21: fs/data/busy/ready=%b want 0000",
               {spi_fs, spi_data, busy, tx_ready});
    end
    reset = 1'b0;
    for (int k = 22; k <= 100; k++) begin
      @(negedge clk);
      total++;
      if ({spi_fs, spi_data, busy, tx_ready} !== 4'b0001) begin
        bad++;
        $display("FAIL post_reset cycle %0d: fs/data/busy/ready=%b want 0001",
                 k, {spi_fs, spi_data, busy, tx_ready});
      end
    end
  endtask

  task automatic test_data_toggle();
    logic [3:0] e;
    send(16'h8000);
    for (int k = 1; k <= int'(FRAME); k++) begin
      @(negedge clk);
      e = exp_out(32'h8000, k, W, D, G);
      total++;
      if ({spi_fs, spi_data, busy, tx_ready} !== e) begin
        bad++;
        $display("FAIL data_toggle cycle %0d: fs/data/busy/ready=%b want %b",
                 k, {spi_fs, spi_data, busy, tx_ready}, e);
      end
      tx_data = ~tx_data;
    end
  endtask

  task automatic test_small_config();
    logic [3:0] e;
    int n;
    n = 0;
    @(negedge clk);
    while (s_tx_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (s_tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL small_wait_ready: s_tx_ready=%b want 1", s_tx_ready);
    end
    s_tx_data  = 8'h3C;
    s_tx_valid = 1'b1;
    @(posedge clk);
    #1 s_tx_valid = 1'b0;
    for (int k = 1; k <= int'(SFRAME); k++) begin
      @(negedge clk);
      e = exp_out(32'h3C, k, SW, SD, SG);
      total++;
      if ({s_spi_fs, s_spi_data, s_busy, s_tx_ready} !== e) begin
        bad++;
        $display("FAIL small_3c cycle %0d: fs/data/busy/ready=%b want %b",
                 k, {s_spi_fs, s_spi_data, s_busy, s_tx_ready}, e);
      end
    end
  endtask

`ifdef SPI_FRAME_TX_PARITY_EN
  task automatic test_parity();
    logic [15:0] words [2];
    logic        pbit [2];
    words[0] = 16'h0007;
    pbit[0]  = 1'b1;
    words[1] = 16'h0003;
    pbit[1]  = 1'b0;
    for (int t = 0; t < 2; t++) begin
      send(words[t]);
      for (int k = 1; k <= 77; k++) begin
        @(negedge clk);
        if (k >= 69 && k <= 72) begin
          total++;
          if (spi_data !== pbit[t]) begin
            bad++;
            $display("FAIL parity word %h cycle %0d: spi_data=%b want %b",
                     words[t], k, spi_data, pbit[t]);
          end
        end
        if (k == 77) begin
          total++;
          if ({busy, tx_ready} !== 2'b01) begin
            bad++;
            $display("FAIL parity_ready word %h cycle 77: busy/ready=%b want 01",
                     words[t], {busy, tx_ready});
          end
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid_frame();
    test_data_toggle();
    test_small_config();
`ifdef SPI_FRAME_TX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule
